id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register that sits directly downstream of the register file.
//  Captures RD1/RD2 and decode control. Applies a same-cycle writeback bypass and detects
//  load-use hazards, inserting a bubble when one is found. Honours flush (taken branch)
//  and downstream hold. Keeps a saturating count of inserted bubbles for debug.
// PARAMETERS
//  ADDR_W   6   register-file address width (matches regfile A1/A2/A3 ports)
//  DATA_W   32  register data width
//  CTRL_W   8   opaque decode control bundle width, passed through unchanged
//  CNT_W    16  bubble-counter width
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  id_valid      in   1       decode slot holds a real instruction
//  id_rs1        in   ADDR_W  source 1 address (also driven to regfile A1)
//  id_rs2        in   ADDR_W  source 2 address (also driven to regfile A2)
//  id_rd         in   ADDR_W  destination address
//  id_use_rs1    in   1       instruction actually reads rs1
//  id_use_rs2    in   1       instruction actually reads rs2
//  id_reg_write  in   1       instruction writes rd
//  id_mem_read   in   1       instruction is a load
//  id_ctrl       in   CTRL_W  remaining control bits
//  id_imm        in   DATA_W  sign-extended immediate
//  id_pc         in   DATA_W  instruction PC
//  rd1, rd2      in   DATA_W  regfile read data (RD1/RD2)
//  wb_we         in   1       writeback write enable (regfile WE)
//  wb_addr       in   ADDR_W  writeback address (regfile A3)
//  wb_data       in   DATA_W  writeback data (regfile WriteData)
//  flush         in   1       kill the instruction entering EX (taken branch/jump)
//  ex_hold       in   1       EX cannot accept; freeze this register
//  stall_id      out  1       combinational: IF/ID must hold this cycle
//  ex_valid      out  1       registered valid
//  ex_rs1, ex_rs2, ex_rd  out ADDR_W  registered addresses
//  ex_reg_write, ex_mem_read  out 1   registered controls (forced 0 when !ex_valid)
//  ex_ctrl       out  CTRL_W  registered control
//  ex_op1, ex_op2 out DATA_W  registered operands after bypass
//  ex_imm, ex_pc out  DATA_W  registered immediate / PC
//  bubble_cnt    out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (async): all registered outputs go to 0, including ex_valid=0 and bubble_cnt=0.
//  - Latency: 1 cycle from ID inputs to ex_* outputs.
//  - Bypass, evaluated per operand: op = (wb_we && wb_addr==rs && rs!=0) ? wb_data : rdX.
//    Any operand with rs==0 is captured as 0, regardless of rdX.
//  - Hazard: haz = id_valid && ex_valid && ex_mem_read && ex_rd!=0 &&
//    ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
//  - stall_id = ex_hold || (haz && !flush).
//  - Per-edge update, highest priority first:
//    1. flush: ex_valid<=0; ex_reg_write/ex_mem_read<=0. Applies even when ex_hold=1.
//    2. ex_hold: every ex_* register keeps its value. Bypass is not re-sampled.
//    3. haz: bubble inserted: ex_valid<=0, controls<=0; bubble_cnt+=1 unless already all-ones.
//    4. otherwise: load all ex_* from ID/bypass; ex_valid<=id_valid.
//    Controls are gated with id_valid.
//  - The hazard clears automatically: after a bubble, ex_mem_read=0, so the same
//    instruction loads on the next edge. Exactly one bubble per load-use pair.
//  - Held-operand rule: while ex_hold=1 the WB stage may retire a register that EX
//    depends on. EX-side forwarding owns that case; this stage does not re-bypass.
//  - Data fields of bubbles (op/imm/pc) are don't-care. The bench checks only valid/controls.
// TESTING
//  - Reset mid-stream: assert reset while ex_valid=1 -> next sample shows all outputs 0.
//  - Bypass: rs1=5, rd1=0x11111111, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF -> ex_op1=0xDEADBEEF.
//    Repeat with rs1=0 -> ex_op1=0.
//  - Load-use: lw x7 in EX, then add rs2=7 (use_rs2=1) -> stall_id=1 for one cycle,
//    ex_valid=0, bubble_cnt=1; next edge add enters with ex_valid=1.
//  - No false hazard: load to x0 or use_rs1=0 with rs1==ex_rd -> stall_id=0, no bubble.
//  - Flush vs hold vs hazard: flush=1, ex_hold=1, haz=1 together -> ex_valid=0,
//    stall_id=1 (hold), bubble_cnt unchanged.
//  - Saturation: preload 2^CNT_W-1 bubbles (CNT_W=4 build: 15) -> one more hazard keeps 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register.
// Captures the register-file read data and the decode control for the instruction
// moving into execute. Operands take the writeback data when WB writes the same
// register in this cycle. A load-use dependency on the load in EX produces a single
// bubble. Flush kills the incoming instruction and ex_hold freezes the register.
// A saturating counter records how many bubbles were inserted.
module id_ex_stage #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [ADDR_W-1:0] ex_rs1,
   output logic [ADDR_W-1:0] ex_rs2,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              haz_s;
   logic [DATA_W-1:0] op1_s;
   logic [DATA_W-1:0] op2_s;

   logic              ex_valid_r;
   logic [ADDR_W-1:0] ex_rs1_r;
   logic [ADDR_W-1:0] ex_rs2_r;
   logic [ADDR_W-1:0] ex_rd_r;
   logic              ex_reg_write_r;
   logic              ex_mem_read_r;
   logic [CTRL_W-1:0] ex_ctrl_r;
   logic [DATA_W-1:0] ex_op1_r;
   logic [DATA_W-1:0] ex_op2_r;
   logic [DATA_W-1:0] ex_imm_r;
   logic [DATA_W-1:0] ex_pc_r;
   logic [CNT_W-1:0]  bubble_cnt_r;

   // Operand 1: x0 reads as zero, else a same-cycle writeback overrides stale RD1
   always_comb begin
      op1_s = rd1;
      if (id_rs1 == REG_ZERO) begin
         op1_s = {DATA_W{1'b0}};
      end else if (wb_we && (wb_addr == id_rs1)) begin
         op1_s = wb_data;
      end else begin
         op1_s = rd1;
      end
   end

   // Operand 2: x0 reads as zero, else a same-cycle writeback overrides stale RD2
   always_comb begin
      op2_s = rd2;
      if (id_rs2 == REG_ZERO) begin
         op2_s = {DATA_W{1'b0}};
      end else if (wb_we && (wb_addr == id_rs2)) begin
         op2_s = wb_data;
      end else begin
         op2_s = rd2;
      end
   end

   // Load-use hazard: the load in EX targets a register the decoding instruction reads
   always_comb begin
      haz_s = 1'b0;
      if (id_valid && ex_valid_r && ex_mem_read_r && (ex_rd_r != REG_ZERO)) begin
         haz_s = (id_use_rs1 && (id_rs1 == ex_rd_r)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd_r));
      end else begin
         haz_s = 1'b0;
      end
   end

   // A flushed hazard is moot, but a hold always stops IF/ID
   assign stall_id = ex_hold | (haz_s & ~flush);

   // Pipeline register update: flush, then hold, then bubble, then normal load
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_valid_r     <= 1'b0;
         ex_rs1_r       <= REG_ZERO;
         ex_rs2_r       <= REG_ZERO;
         ex_rd_r        <= REG_ZERO;
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         ex_ctrl_r      <= {CTRL_W{1'b0}};
         ex_op1_r       <= {DATA_W{1'b0}};
         ex_op2_r       <= {DATA_W{1'b0}};
         ex_imm_r       <= {DATA_W{1'b0}};
         ex_pc_r        <= {DATA_W{1'b0}};
         bubble_cnt_r   <= {CNT_W{1'b0}};
      end else if (flush) begin
         ex_valid_r     <= 1'b0;
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
      end else if (ex_hold) begin
         // Everything keeps its value; operands are not re-bypassed while held
         ex_valid_r     <= ex_valid_r;
      end else if (haz_s) begin
         ex_valid_r     <= 1'b0;
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         if (bubble_cnt_r != CNT_MAX) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end else begin
         ex_valid_r     <= id_valid;
         ex_rs1_r       <= id_rs1;
         ex_rs2_r       <= id_rs2;
         ex_rd_r        <= id_rd;
         ex_reg_write_r <= id_valid & id_reg_write;
         ex_mem_read_r  <= id_valid & id_mem_read;
         ex_ctrl_r      <= id_ctrl;
         ex_op1_r       <= op1_s;
         ex_op2_r       <= op2_s;
         ex_imm_r       <= id_imm;
         ex_pc_r        <= id_pc;
      end
   end

   assign ex_valid     = ex_valid_r;
   assign ex_rs1       = ex_rs1_r;
   assign ex_rs2       = ex_rs2_r;
   assign ex_rd        = ex_rd_r;
   assign ex_reg_write = ex_reg_write_r;
   assign ex_mem_read  = ex_mem_read_r;
   assign ex_ctrl      = ex_ctrl_r;
   assign ex_op1       = ex_op1_r;
   assign ex_op2       = ex_op2_r;
   assign ex_imm       = ex_imm_r;
   assign ex_pc        = ex_pc_r;
   assign bubble_cnt   = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of what EX must hold.
module tb_id_ex_stage;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic              clock;
   logic              reset;
   logic              id_valid;
   logic [ADDR_W-1:0] id_rs1, id_rs2, id_rd;
   logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic [CTRL_W-1:0] id_ctrl;
   logic [DATA_W-1:0] id_imm, id_pc, rd1, rd2;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              flush, ex_hold;
   logic              stall_id, ex_valid;
   logic [ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic              ex_reg_write, ex_mem_read;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [DATA_W-1:0] ex_op1, ex_op2, ex_imm, ex_pc;
   logic [CNT_W-1:0]  bubble_cnt;

   int errors = 0;
   int checks = 0;

   id_ex_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
      .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .bubble_cnt(bubble_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model: contents of the EX slot ----------------
   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] rs1, rs2, rd;
      logic              rw, mr;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] op1, op2, imm, pc;
   } ex_t;

   ex_t m;
   int  m_bub;

   // Value the register named rs holds as seen by decode this cycle
   function automatic logic [DATA_W-1:0] reg_value(input logic [ADDR_W-1:0] rs,
                                                   input logic [DATA_W-1:0] rdata);
      if (rs == 0) return 0;
      if (wb_we && wb_addr == rs) return wb_data;
      return rdata;
   endfunction

   function automatic bit model_haz();
      if (!(id_valid && m.v && m.mr && m.rd != 0)) return 1'b0;
      return (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m     <= '0;
         m_bub <= 0;
      end else if (flush) begin
         m.v  <= 1'b0;
         m.rw <= 1'b0;
         m.mr <= 1'b0;
      end else if (ex_hold) begin
         m <= m;
      end else if (model_haz()) begin
         m.v  <= 1'b0;
         m.rw <= 1'b0;
         m.mr <= 1'b0;
         m_bub <= (m_bub < CNT_SAT) ? m_bub + 1 : m_bub;
      end else begin
         m <= '{v: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                rw: id_valid && id_reg_write, mr: id_valid && id_mem_read,
                ctrl: id_ctrl, op1: reg_value(id_rs1, rd1), op2: reg_value(id_rs2, rd2),
                imm: id_imm, pc: id_pc};
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle, compare the DUT against the model away from the clock edge
   always @(negedge clock) begin
      chk("ex_valid", 64'(ex_valid), 64'(m.v));
      chk("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
      chk("ex_mem_read", 64'(ex_mem_read), 64'(m.mr));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
      chk("stall_id", 64'(stall_id), 64'(ex_hold || (model_haz() && !flush)));
      if (m.v) begin
         chk("ex_rs1", 64'(ex_rs1), 64'(m.rs1));
         chk("ex_rs2", 64'(ex_rs2), 64'(m.rs2));
         chk("ex_rd", 64'(ex_rd), 64'(m.rd));
         chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
         chk("ex_op1", 64'(ex_op1), 64'(m.op1));
         chk("ex_op2", 64'(ex_op2), 64'(m.op2));
         chk("ex_imm", 64'(ex_imm), 64'(m.imm));
         chk("ex_pc", 64'(ex_pc), 64'(m.pc));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      id_ctrl = '0; id_imm = '0; id_pc = '0; rd1 = '0; rd2 = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; ex_hold = 1'b0;
   endtask

   task automatic load_to(input logic [ADDR_W-1:0] rd);
      quiet();
      id_valid = 1'b1; id_rd = rd; id_reg_write = 1'b1; id_mem_read = 1'b1;
      id_pc = 32'h0000_1000;
   endtask

   task automatic use_of(input logic [ADDR_W-1:0] rs2);
      quiet();
      id_valid = 1'b1; id_rs1 = 6'd3; id_use_rs1 = 1'b1; id_rs2 = rs2; id_use_rs2 = 1'b1;
      id_rd = 6'd9; id_reg_write = 1'b1; id_ctrl = 8'h5A; id_pc = 32'h0000_1004;
   endtask

   task automatic rand_in();
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs1       = 6'($urandom_range(0, 7));
      id_rs2       = 6'($urandom_range(0, 7));
      id_rd        = 6'($urandom_range(0, 7));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_ctrl      = 8'($urandom);
      id_imm       = $urandom;
      id_pc        = $urandom;
      rd1          = $urandom;
      rd2          = $urandom;
      wb_we        = 1'($urandom_range(0, 1));
      wb_addr      = 6'($urandom_range(0, 7));
      wb_data      = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      ex_hold      = ($urandom_range(0, 5) == 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b1;
      quiet();
      repeat (3) @(posedge clock);
      #1;
      chk("reset_valid", 64'(ex_valid), 64'd0);
      chk("reset_bubbles", 64'(bubble_cnt), 64'd0);
      reset = 1'b0;

      // Bypass from writeback, then x0 forced to zero
      quiet();
      id_valid = 1'b1; id_rs1 = 6'd5; id_use_rs1 = 1'b1; rd1 = 32'h1111_1111;
      wb_we = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEAD_BEEF;
      tick();
      chk("bypass_op1", 64'(ex_op1), 64'h0000_0000_DEAD_BEEF);
      id_rs1 = 6'd0; wb_addr = 6'd0;
      tick();
      chk("x0_op1", 64'(ex_op1), 64'd0);

      // Load-use: exactly one bubble, then the consumer enters
      load_to(6'd7);
      tick();
      use_of(6'd7);
      #1;
      chk("lu_stall", 64'(stall_id), 64'd1);
      tick();
      chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
      chk("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
      chk("lu_stall_clear", 64'(stall_id), 64'd0);
      tick();
      chk("lu_enter_valid", 64'(ex_valid), 64'd1);
      chk("lu_enter_rd", 64'(ex_rd), 64'd9);

      // No false hazard: load to x0, and a matching rs1 that is not used
      load_to(6'd0);
      tick();
      quiet();
      id_valid = 1'b1; id_rs1 = 6'd0; id_use_rs1 = 1'b1;
      #1;
      chk("x0_load_stall", 64'(stall_id), 64'd0);
      load_to(6'd4);
      tick();
      quiet();
      id_valid = 1'b1; id_rs1 = 6'd4; id_use_rs1 = 1'b0;
      #1;
      chk("unused_rs1_stall", 64'(stall_id), 64'd0);
      tick();
      chk("no_false_bubble", 64'(bubble_cnt), 64'd1);

      // Flush, hold and hazard together
      load_to(6'd8);
      tick();
      use_of(6'd8);
      flush = 1'b1; ex_hold = 1'b1;
      #1;
      chk("fhh_stall", 64'(stall_id), 64'd1);
      tick();
      chk("fhh_valid", 64'(ex_valid), 64'd0);
      chk("fhh_bubbles", 64'(bubble_cnt), 64'd1);

      // Saturation: fifteen more bubbles on top of one must stop at 15
      for (int i = 0; i < 15; i++) begin
         load_to(6'd7);
         tick();
         use_of(6'd7);
         tick();
         tick();
      end
      chk("sat_bubbles", 64'(bubble_cnt), 64'd15);

      // Reset while a valid instruction sits in EX
      quiet();
      id_valid = 1'b1; id_rd = 6'd2; id_reg_write = 1'b1; id_imm = 32'h0000_00FF;
      tick();
      chk("pre_reset_valid", 64'(ex_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_reset_valid", 64'(ex_valid), 64'd0);
      chk("mid_reset_rw", 64'(ex_reg_write), 64'd0);
      chk("mid_reset_imm", 64'(ex_imm), 64'd0);
      chk("mid_reset_rd", 64'(ex_rd), 64'd0);
      chk("mid_reset_cnt", 64'(bubble_cnt), 64'd0);
      #1;
      reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rand_in();
         tick();
      end

      quiet();
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
